note_input_encoder: RTL



---
 rtl/note_input_encoder_pkg.sv | 60 ++++++
 rtl/note_input_encoder_if.sv | 28 ++
 rtl/note_input_encoder_debounce_vec.sv | 43 ++++
 rtl/note_input_encoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/note_input_encoder_pkg.sv
// Constants shared by the note input encoder, the LED driver and the tone generator.
// Covers the note codes, the octave encodings, the FSM states and the key/octave decode helpers.
package note_input_encoder_pkg;

  typedef enum logic [2:0] {
    n_space = 3'd0,
    n_do    = 3'd1,
    n_re    = 3'd2,
    n_mi    = 3'd3,
    n_fa    = 3'd4,
    n_so    = 3'd5,
    n_la    = 3'd6,
    n_q1    = 3'd7
  } note_t;

  localparam logic [1:0] oct_normal = 2'b00;
  localparam logic [1:0] oct_high   = 2'b01;
  localparam logic [1:0] oct_low    = 2'b10;

  typedef enum logic [1:0] {
    st_idle     = 2'd0,
    st_held     = 2'd1,
    st_conflict = 2'd2
  } state_t;

  typedef struct packed {
    note_t code;
    logic  single;
    logic  multi;
  } key_enc_t;

  // code is n_space unless exactly one key is down
  function automatic key_enc_t encode_keys(input logic [6:0] keys);
    key_enc_t   enc;
    logic [2:0] ones;
    enc.code = n_space;
    ones     = '0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (keys[i]) begin
        ones     = ones + 3'd1;
        enc.code = note_t'(3'(i + 1));
      end
    end
    enc.single = (ones == 3'd1);
    enc.multi  = (ones > 3'd1);
    if (!enc.single) enc.code = n_space;
    return enc;
  endfunction

  function automatic logic [1:0] decode_octave(input logic [1:0] btn);
    logic [1:0] oct;
    case (btn)
      oct_low:  oct = oct_low;
      oct_high: oct = oct_high;
      default:  oct = oct_normal;
    endcase
    return oct;
  endfunction

endpackage

// File: rtl/note_input_encoder_if.sv
// Raw note/octave inputs and encoded note events exchanged with the note input encoder.
interface note_input_encoder_if #(
  parameter int unsigned HOLD_W = 16
);
  logic              EN;
  logic [6:0]        note_sw;
  logic [1:0]        octave_btn;
  logic [2:0]        note_code;
  logic              note_valid;
  logic              note_press;
  logic              note_release;
  logic [1:0]        octave;
  logic [1:0]        press_octave;
  logic [HOLD_W-1:0] hold_len;
  logic              multi_key;

  modport master (
    output EN, note_sw, octave_btn,
    input  note_code, note_valid, note_press, note_release,
           octave, press_octave, hold_len, multi_key
  );

  modport slave (
    input  EN, note_sw, octave_btn,
    output note_code, note_valid, note_press, note_release,
           octave, press_octave, hold_len, multi_key
  );
endinterface

// File: rtl/note_input_encoder_debounce_vec.sv
// Two-flop synchroniser plus whole-vector debounce: the vector must be unchanged
// for DB_CYCLES consecutive synchronised samples before it becomes stable.
module debounce_vec #(
  parameter int unsigned W         = 7,
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int unsigned   CW       = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_COPY = CW'(DB_CYCLES - 2);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync2;
  logic [W-1:0]  cand;
  logic [CW-1:0] cnt;

  // Copy happens on the increment that reaches DB_CYCLES-1 and every cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        if (cnt >= CNT_COPY) stable <= cand;
      end
    end
  end

endmodule

// File: rtl/note_input_encoder.sv
// Debounces the note switches and octave buttons, then tracks the held note
// and emits registered press/release events, octave and hold duration.
module note_input_encoder
  import note_input_encoder_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 2_000_000,
  parameter int unsigned TICK_CYCLES = 100_000,
  parameter int unsigned HOLD_W      = 16
) (
  input logic                clk,
  input logic                rst,
  note_input_encoder_if.slave bus
);

  localparam int unsigned   TW        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [6:0]        keys;
  logic [1:0]        oct_stable;
  key_enc_t          enc;
  logic [1:0]        oct_now;

  state_t            state, state_d;
  note_t             code_q, code_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              valid_q, multi_q;
  logic [1:0]        octave_q;
  logic [1:0]        poct_q, poct_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TW-1:0]     tick_q, tick_d;

  debounce_vec #(.W(7), .DB_CYCLES(DB_CYCLES)) u_sw_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.note_sw),
    .stable (keys)
  );

  debounce_vec #(.W(2), .DB_CYCLES(DB_CYCLES)) u_oct_db (
    .clk    (clk),
    .rst    (rst),
    .raw    (bus.octave_btn),
    .stable (oct_stable)
  );

  always_comb begin
    enc     = encode_keys(keys);
    oct_now = decode_octave(oct_stable);
  end

  always_comb begin
    state_d = state;
    code_d  = code_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    poct_d  = poct_q;
    hold_d  = hold_q;
    tick_d  = tick_q;
    unique case (state)
      st_idle: begin
        if (bus.EN && enc.single) begin
          state_d = st_held;
          press_d = 1'b1;
          code_d  = enc.code;
          poct_d  = oct_now;
          hold_d  = '0;
          tick_d  = '0;
        end else if (bus.EN && enc.multi) begin
          state_d = st_conflict;
        end
      end
      st_held: begin
        if (!bus.EN || !enc.single) begin
          state_d = enc.multi && bus.EN ? st_conflict : st_idle;
          rel_d   = 1'b1;
          code_d  = n_space;
        end else if (enc.code != code_q) begin
          // slide: end the old note and start the new one on the same edge
          rel_d   = 1'b1;
          press_d = 1'b1;
          code_d  = enc.code;
          poct_d  = oct_now;
          hold_d  = '0;
          tick_d  = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      st_conflict: begin
        if (!bus.EN || (!enc.single && !enc.multi)) state_d = st_idle;
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= st_idle;
      code_q   <= n_space;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      octave_q <= '0;
      poct_q   <= '0;
      hold_q   <= '0;
      tick_q   <= '0;
    end else begin
      state    <= state_d;
      code_q   <= code_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      valid_q  <= (state_d == st_held);
      multi_q  <= (state_d == st_conflict);
      octave_q <= oct_now;
      poct_q   <= poct_d;
      hold_q   <= hold_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.note_code    = code_q;
  assign bus.note_valid   = valid_q;
  assign bus.note_press   = press_q;
  assign bus.note_release = rel_q;
  assign bus.octave       = octave_q;
  assign bus.press_octave = poct_q;
  assign bus.hold_len     = hold_q;
  assign bus.multi_key    = multi_q;

endmodule
